muldiv_issue: RTL and testbench

//  Issue/retire controller between the execute stage and the iterative muldiv unit.

---
 rtl/muldiv_issue_pkg.sv | 62 ++++++
 rtl/muldiv_issue_if.sv | 44 ++++
 rtl/muldiv_result_cache.sv | 52 +++++
 rtl/muldiv_issue.sv | 118 +++++++++++
 tb/tb_muldiv_issue.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_issue_pkg.sv
// ============================================================================
// Module : muldiv_issue_pkg
// Brief  : Shared types for the muldiv issue/retire controller.
//          Optional MULDIV_RESULT_CACHE_EN adds cache fields to the state reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_issue_pkg;

    localparam int XLEN    = 32;
    localparam int REGADDR = 5;

    // One-hot op vector, mul is the MSB; layout shared with the muldiv unit
    typedef struct packed {
        logic mul;
        logic mulh;
        logic mulhsu;
        logic mulhu;
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } muldiv_op_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } muldiv_issue_state_type;

    typedef struct packed {
        muldiv_issue_state_type state;
        logic [REGADDR-1:0]     waddr;
`ifdef MULDIV_RESULT_CACHE_EN
        muldiv_op_type          op;
        logic [XLEN-1:0]        rdata1;
        logic [XLEN-1:0]        rdata2;
`endif
        logic                   wb_valid;
        logic [REGADDR-1:0]     wb_waddr;
        logic [XLEN-1:0]        wb_data;
    } muldiv_issue_reg_type;

    typedef struct packed {
        logic            valid;
        muldiv_op_type   op;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] result;
    } muldiv_cache_entry_type;

    function automatic muldiv_issue_reg_type init_muldiv_issue_reg();
        muldiv_issue_reg_type r;
        r       = '0;
        r.state = IDLE;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_issue_if.sv
// ============================================================================
// Module : muldiv_issue_if
// Brief  : Execute-side request, muldiv unit and writeback signal bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_issue_if;
    import muldiv_issue_pkg::*;

    logic                req_valid;
    muldiv_op_type       req_op;
    logic [XLEN-1:0]     req_rdata1;
    logic [XLEN-1:0]     req_rdata2;
    logic [REGADDR-1:0]  req_waddr;
    logic                flush;
    logic                stall;
    logic                md_enable;
    muldiv_op_type       md_op;
    logic [XLEN-1:0]     md_rdata1;
    logic [XLEN-1:0]     md_rdata2;
    logic                md_ready;
    logic [XLEN-1:0]     md_result;
    logic                wb_valid;
    logic [REGADDR-1:0]  wb_waddr;
    logic [XLEN-1:0]     wb_data;

    modport master (
        output req_valid, req_op, req_rdata1, req_rdata2, req_waddr, flush,
        output md_ready, md_result,
        input  stall, md_enable, md_op, md_rdata1, md_rdata2,
        input  wb_valid, wb_waddr, wb_data
    );

    modport slave (
        input  req_valid, req_op, req_rdata1, req_rdata2, req_waddr, flush,
        input  md_ready, md_result,
        output stall, md_enable, md_op, md_rdata1, md_rdata2,
        output wb_valid, wb_waddr, wb_data
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_result_cache.sv
// ============================================================================
// Module : muldiv_result_cache
// Brief  : One-entry result cache with exact-match lookup; cleared only by reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_result_cache
    import muldiv_issue_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            wr_en,
    input  muldiv_op_type        wr_op,
    input  wire logic [XLEN-1:0] wr_rdata1,
    input  wire logic [XLEN-1:0] wr_rdata2,
    input  wire logic [XLEN-1:0] wr_result,
    input  muldiv_op_type        lu_op,
    input  wire logic [XLEN-1:0] lu_rdata1,
    input  wire logic [XLEN-1:0] lu_rdata2,
    output logic                 hit,
    output logic [XLEN-1:0]      hit_result
);

    muldiv_cache_entry_type entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (wr_en) begin
            entry_d.valid  = 1'b1;
            entry_d.op     = wr_op;
            entry_d.rdata1 = wr_rdata1;
            entry_d.rdata2 = wr_rdata2;
            entry_d.result = wr_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign hit = entry_q.valid && (entry_q.op == lu_op) &&
                 (entry_q.rdata1 == lu_rdata1) && (entry_q.rdata2 == lu_rdata2);
    assign hit_result = entry_q.result;

endmodule

`default_nettype wire

// File: rtl/muldiv_issue.sv
// ============================================================================
// Module : muldiv_issue
// Brief  : Issue/retire controller for the iterative muldiv unit; stalls
//          execute while an op is in flight and drains ops killed by flush.
//          Define MULDIV_RESULT_CACHE_EN to add a one-entry result cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_issue
    import muldiv_issue_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    muldiv_issue_if.slave bus
);

    muldiv_issue_reg_type reg_q, reg_d;
    logic                 stall;
    logic                 md_enable;
    logic                 cache_hit;
    logic [XLEN-1:0]      cache_result;

`ifdef MULDIV_RESULT_CACHE_EN
    logic cache_wr;

    // Flush-discarded results never reach the cache
    assign cache_wr = (reg_q.state == WAIT) && bus.md_ready && !bus.flush;

    muldiv_result_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cache_wr),
        .wr_op      (reg_q.op),
        .wr_rdata1  (reg_q.rdata1),
        .wr_rdata2  (reg_q.rdata2),
        .wr_result  (bus.md_result),
        .lu_op      (bus.req_op),
        .lu_rdata1  (bus.req_rdata1),
        .lu_rdata2  (bus.req_rdata2),
        .hit        (cache_hit),
        .hit_result (cache_result)
    );
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        reg_d          = reg_q;
        reg_d.wb_valid = 1'b0;
        stall          = 1'b0;
        md_enable      = 1'b0;
        unique case (reg_q.state)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    if (cache_hit) begin
                        reg_d.wb_valid = 1'b1;
                        reg_d.wb_data  = cache_result;
                        reg_d.wb_waddr = bus.req_waddr;
                    end else begin
                        md_enable    = 1'b1;
                        stall        = 1'b1;
                        reg_d.waddr  = bus.req_waddr;
`ifdef MULDIV_RESULT_CACHE_EN
                        reg_d.op     = bus.req_op;
                        reg_d.rdata1 = bus.req_rdata1;
                        reg_d.rdata2 = bus.req_rdata2;
`endif
                        reg_d.state  = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.md_ready && !bus.flush) begin
                    stall          = 1'b0;
                    reg_d.wb_valid = 1'b1;
                    reg_d.wb_data  = bus.md_result;
                    reg_d.wb_waddr = reg_q.waddr;
                    reg_d.state    = IDLE;
                end else if (bus.flush) begin
                    reg_d.state = bus.md_ready ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                // The unit cannot abort; wait out its result and drop it
                stall = bus.req_valid;
                if (bus.md_ready) begin
                    reg_d.state = IDLE;
                end
            end
            default: begin
                reg_d.state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_q <= init_muldiv_issue_reg();
        end else begin
            reg_q <= reg_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.md_enable = md_enable;
    assign bus.md_op     = bus.req_op;
    assign bus.md_rdata1 = bus.req_rdata1;
    assign bus.md_rdata2 = bus.req_rdata2;
    assign bus.wb_valid  = reg_q.wb_valid;
    assign bus.wb_waddr  = reg_q.wb_waddr;
    assign bus.wb_data   = reg_q.wb_data;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_issue.sv
// ============================================================================
// Module : tb_muldiv_issue
// Brief  : Self-checking bench for muldiv_issue with a latency-controlled
//          muldiv unit model and a writeback scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_issue;

    localparam logic [7:0] OP_MUL    = 8'h80;
    localparam logic [7:0] OP_MULH   = 8'h40;
    localparam logic [7:0] OP_MULHSU = 8'h20;
    localparam logic [7:0] OP_MULHU  = 8'h10;
    localparam logic [7:0] OP_DIV    = 8'h08;
    localparam logic [7:0] OP_DIVU   = 8'h04;
    localparam logic [7:0] OP_REM    = 8'h02;
    localparam logic [7:0] OP_REMU   = 8'h01;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] sb_data[$];
    logic [4:0]  sb_addr[$];

    muldiv_issue_if bus ();

    muldiv_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference muldiv unit: RISC-V M-extension semantics
    function automatic logic [31:0] md_model(logic [7:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = '0;
        case (op)
            OP_MUL:    p = {32'b0, a * b};
            OP_MULH:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULHSU: p = {{32{a[31]}}, a} * {32'b0, b};
            OP_MULHU:  p = {32'b0, a} * {32'b0, b};
            default:   p = '0;
        endcase
        case (op)
            OP_MUL:                       return p[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
            OP_DIV:  if (b == 0) return 32'hFFFFFFFF;
                     else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                     else return $signed(a) / $signed(b);
            OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_REM:  if (b == 0) return a;
                     else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                     else return $signed(a) % $signed(b);
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(logic [7:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_rdata1 = a;
        bus.req_rdata2 = b;
        bus.req_waddr  = rd;
    endtask

    // Launch, hold for lat cycles, answer with md_ready and check writeback
    task automatic do_op(string name, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, logic [31:0] exp, int lat);
        logic [31:0] ed;
        logic [4:0]  ea;
        present(op, a, b, rd);
        bus.flush = 1'b0;
        #1;
        total++;
        if (bus.md_enable !== 1'b1 || bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL %s launch: md_enable=%b stall=%b required 1 1", name, bus.md_enable, bus.stall);
        end
        total++;
        if (bus.md_op !== op || bus.md_rdata1 !== a || bus.md_rdata2 !== b) begin
            bad++;
            $display("FAIL %s passthrough: op=%h a=%h b=%h required %h %h %h",
                     name, bus.md_op, bus.md_rdata1, bus.md_rdata2, op, a, b);
        end
        sb_data.push_back(exp);
        sb_addr.push_back(rd);
        step();
        for (int i = 1; i < lat; i++) begin
            total++;
            if (bus.md_enable !== 1'b0 || bus.stall !== 1'b1 || bus.wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s wait cycle %0d: md_enable=%b stall=%b wb_valid=%b required 0 1 0",
                         name, i, bus.md_enable, bus.stall, bus.wb_valid);
            end
            step();
        end
        bus.md_ready  = 1'b1;
        bus.md_result = md_model(op, a, b);
        #1;
        total++;
        if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s retire: stall=%b wb_valid=%b required 0 0", name, bus.stall, bus.wb_valid);
        end
        step();
        bus.md_ready  = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        ed = (sb_data.size() != 0) ? sb_data.pop_front() : 32'hx;
        ea = (sb_addr.size() != 0) ? sb_addr.pop_front() : 5'hx;
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== ed || bus.wb_waddr !== ea) begin
            bad++;
            $display("FAIL %s wb: wb_valid=%b data=%h waddr=%0d required 1 %h %0d",
                     name, bus.wb_valid, bus.wb_data, bus.wb_waddr, ed, ea);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 8'h0;
        bus.req_rdata1 = '0;
        bus.req_rdata2 = '0;
        bus.req_waddr  = '0;
        bus.flush      = 1'b0;
        bus.md_ready   = 1'b0;
        bus.md_result  = '0;
        step();
        step();
        total++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0 || bus.wb_waddr !== 5'h0) begin
            bad++;
            $display("FAIL reset wb: valid=%b data=%h waddr=%0d required 0 0 0", bus.wb_valid, bus.wb_data, bus.wb_waddr);
        end
        total++;
        if (bus.stall !== 1'b0 || bus.md_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset ctl: stall=%b md_enable=%b required 0 0", bus.stall, bus.md_enable);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_mul();
        do_op("mul7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 3);
    endtask

    task automatic test_div_back_to_back();
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000, 33);
        do_op("divu_by0", OP_DIVU, 32'd10, 32'd0, 5'd7, 32'hFFFFFFFF, 1);
        do_op("mulh_neg", OP_MULH, 32'hFFFFFFFE, 32'd3, 5'd8, 32'hFFFFFFFF, 2);
        do_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd9, 32'hFFFFFFFF, 4);
        do_op("remu", OP_REMU, 32'd17, 32'd5, 5'd10, 32'd2, 7);
        do_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0, 1);
    endtask

    task automatic test_flush_drain();
        present(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd9);
        step();
        for (int i = 1; i < 5; i++) step();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b0;
        step();
        bus.flush = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b0 || bus.md_enable !== 1'b0 || bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain idle: stall=%b md_enable=%b wb_valid=%b required 0 0 0",
                     bus.stall, bus.md_enable, bus.wb_valid);
        end
        step();
        present(OP_MUL, 32'd3, 32'd4, 5'd12);
        #1;
        total++;
        if (bus.stall !== 1'b1 || bus.md_enable !== 1'b0) begin
            bad++;
            $display("FAIL drain req: stall=%b md_enable=%b required 1 0", bus.stall, bus.md_enable);
        end
        step();
        bus.md_ready  = 1'b1;
        bus.md_result = 32'hDEAD0001;
        step();
        bus.md_ready = 1'b0;
        #1;
        total++;
        if (bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain discard: wb_valid=%b required 0", bus.wb_valid);
        end
        do_op("after_drain", OP_MUL, 32'd3, 32'd4, 5'd12, 32'd12, 2);
    endtask

    task automatic test_flush_with_ready();
        present(OP_MUL, 32'd2, 32'd2, 5'd13);
        step();
        step();
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd4;
        bus.flush     = 1'b1;
        bus.req_valid = 1'b0;
        step();
        bus.md_ready = 1'b0;
        bus.flush    = 1'b0;
        #1;
        total++;
        if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: wb_valid=%b stall=%b required 0 0", bus.wb_valid, bus.stall);
        end
        do_op("after_kill", OP_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 4);
    endtask

    task automatic test_reset_mid_wait();
        present(OP_MULH, 32'd9, 32'd9, 5'd15);
        step();
        step();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        step();
        rst = 1'b1;
        total++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0 || bus.wb_waddr !== 5'h0 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: wb_valid=%b data=%h waddr=%0d stall=%b required 0 0 0 0",
                     bus.wb_valid, bus.wb_data, bus.wb_waddr, bus.stall);
        end
        do_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd13, 32'd1, 5);
    endtask

    task automatic test_idle_ready();
        step();
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd55;
        step();
        bus.md_ready = 1'b0;
        #1;
        total++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'd1) begin
            bad++;
            $display("FAIL idle_ready: wb_valid=%b data=%h required 0 00000001", bus.wb_valid, bus.wb_data);
        end
    endtask

    task automatic test_cache();
        do_op("c_mulh", OP_MULH, 32'd3, 32'd5, 5'd16, 32'd0, 3);
        do_op("c_mul", OP_MUL, 32'd3, 32'd5, 5'd17, 32'd15, 2);
`ifdef MULDIV_RESULT_CACHE_EN
        begin
            logic [31:0] ed;
            logic [4:0]  ea;
            present(OP_MUL, 32'd3, 32'd5, 5'd18);
            #1;
            total++;
            if (bus.md_enable !== 1'b0 || bus.stall !== 1'b0) begin
                bad++;
                $display("FAIL cache hit: md_enable=%b stall=%b required 0 0", bus.md_enable, bus.stall);
            end
            sb_data.push_back(32'd15);
            sb_addr.push_back(5'd18);
            step();
            bus.req_valid = 1'b0;
            #1;
            ed = (sb_data.size() != 0) ? sb_data.pop_front() : 32'hx;
            ea = (sb_addr.size() != 0) ? sb_addr.pop_front() : 5'hx;
            total++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== ed || bus.wb_waddr !== ea) begin
                bad++;
                $display("FAIL cache wb: wb_valid=%b data=%h waddr=%0d required 1 %h %0d",
                         bus.wb_valid, bus.wb_data, bus.wb_waddr, ed, ea);
            end
        end
`else
        do_op("c_mulh2", OP_MULH, 32'd3, 32'd5, 5'd18, 32'd0, 6);
`endif
        step();
        total++;
        if (sb_data.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d entries left required 0", sb_data.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_div_back_to_back();
        test_flush_drain();
        test_flush_with_ready();
        test_reset_mid_wait();
        test_idle_ready();
        test_cache();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
